// File: rtl/bp_chooser.sv
// Tournament chooser: picks local or global prediction per branch via 2-bit
// choice counters, tracks predictions through D/E/M and trains on retire.
module bp_chooser #(
    parameter int CPHT_DEPTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CPHT_DEPTH-1:0] hashed_pcF,
    input  logic [CPHT_DEPTH-1:0] hashed_pcM,
    input  logic                  branchF,
    input  logic                  local_predF,
    input  logic                  global_predF,
    input  logic                  stallD,
    input  logic                  stallE,
    input  logic                  stallM,
    input  logic                  flushD,
    input  logic                  flushE,
    input  logic                  flushM,
    input  logic                  branchM,
    input  logic                  pcsrcM,
    output logic                  pcsrcPF,
    output logic                  predict_wrongM,
    output logic [31:0]           branch_cnt,
    output logic [31:0]           miss_cnt
);

    localparam int ENTRIES = 1 << CPHT_DEPTH;

    // stage bundle bit positions: {valid, local, global, final}
    localparam int B_V = 3;
    localparam int B_L = 2;
    localparam int B_G = 1;
    localparam int B_F = 0;

    logic [1:0] r_cpht [ENTRIES];
    logic [3:0] r_d;
    logic [3:0] r_e;
    logic [3:0] r_m;
    logic [31:0] r_branch_cnt;
    logic [31:0] r_miss_cnt;

    logic [1:0] w_choice;
    logic       w_pred;
    logic       w_wrong;
    logic       w_ret;
    logic       w_loc_ok;
    logic       w_glb_ok;
    logic [1:0] w_cur;
    logic [1:0] w_nxt;

    // final prediction: choice counter MSB selects global over local
    always_comb begin
        w_choice = r_cpht[hashed_pcF];
        w_pred   = branchF & (w_choice[1] ? global_predF : local_predF);
    end

    // mispredict detection and retire qualification in M
    always_comb begin
        w_wrong = branchM & r_m[B_V] & (r_m[B_F] != pcsrcM);
        w_ret   = branchM & r_m[B_V] & ~stallM;
    end

    // saturating update of the chooser entry owned by the retiring branch
    always_comb begin
        w_cur    = r_cpht[hashed_pcM];
        w_nxt    = w_cur;
        w_loc_ok = (r_m[B_L] == pcsrcM);
        w_glb_ok = (r_m[B_G] == pcsrcM);
        if (w_loc_ok && !w_glb_ok && w_cur != 2'b00) begin
            w_nxt = w_cur - 2'b01;
        end else if (w_glb_ok && !w_loc_ok && w_cur != 2'b11) begin
            w_nxt = w_cur + 2'b01;
        end
    end

    // chooser table: reset to weakly-local, trained only on retire
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_cpht[i] <= 2'b01;
            end
        end else if (w_ret) begin
            r_cpht[hashed_pcM] <= w_nxt;
        end
    end

    // shadow stage D captures the F prediction
    always_ff @(posedge clk) begin
        if (rst || flushD) begin
            r_d <= '0;
        end else if (!stallD) begin
            r_d <= {branchF, local_predF, global_predF, w_pred};
        end
    end

    // shadow stage E
    always_ff @(posedge clk) begin
        if (rst || flushE) begin
            r_e <= '0;
        end else if (!stallE) begin
            r_e <= r_d;
        end
    end

    // shadow stage M
    always_ff @(posedge clk) begin
        if (rst || flushM) begin
            r_m <= '0;
        end else if (!stallM) begin
            r_m <= r_e;
        end
    end

    // retire statistics, free-running wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt <= '0;
            r_miss_cnt   <= '0;
        end else if (w_ret) begin
            r_branch_cnt <= r_branch_cnt + 32'd1;
            if (w_wrong) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign pcsrcPF        = w_pred;
    assign predict_wrongM = w_wrong;
    assign branch_cnt     = r_branch_cnt;
    assign miss_cnt       = r_miss_cnt;

endmodule

// File: tb/tb_bp_chooser.sv
// Directed bench for bp_chooser: driver queues hand-computed expectations,
// a monitor pops and compares them every cycle.
module tb_bp_chooser;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  hashed_pcF;
    logic [5:0]  hashed_pcM;
    logic        branchF;
    logic        local_predF;
    logic        global_predF;
    logic        stallD, stallE, stallM;
    logic        flushD, flushE, flushM;
    logic        branchM;
    logic        pcsrcM;
    logic        pcsrcPF;
    logic        predict_wrongM;
    logic [31:0] branch_cnt;
    logic [31:0] miss_cnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string       nm;
        bit          cpf;
        logic        pf;
        logic        pw;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t sb[$];

    bp_chooser #(.CPHT_DEPTH(6)) dut (
        .clk(clk),
        .rst(rst),
        .hashed_pcF(hashed_pcF),
        .hashed_pcM(hashed_pcM),
        .branchF(branchF),
        .local_predF(local_predF),
        .global_predF(global_predF),
        .stallD(stallD),
        .stallE(stallE),
        .stallM(stallM),
        .flushD(flushD),
        .flushE(flushE),
        .flushM(flushM),
        .branchM(branchM),
        .pcsrcM(pcsrcM),
        .pcsrcPF(pcsrcPF),
        .predict_wrongM(predict_wrongM),
        .branch_cnt(branch_cnt),
        .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // monitor: compare DUT outputs mid-cycle against queued expectations
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cpf) begin
                checks++;
                if (pcsrcPF !== e.pf) begin
                    failures++;
                    $display("FAIL %s pcsrcPF got=%b exp=%b", e.nm, pcsrcPF, e.pf);
                end
            end
            checks++;
            if (predict_wrongM !== e.pw) begin
                failures++;
                $display("FAIL %s predict_wrongM got=%b exp=%b",
                         e.nm, predict_wrongM, e.pw);
            end
            checks++;
            if (branch_cnt !== e.bc) begin
                failures++;
                $display("FAIL %s branch_cnt got=%0d exp=%0d", e.nm, branch_cnt, e.bc);
            end
            checks++;
            if (miss_cnt !== e.mc) begin
                failures++;
                $display("FAIL %s miss_cnt got=%0d exp=%0d", e.nm, miss_cnt, e.mc);
            end
        end
    end

    task automatic setF(input logic b, input logic [5:0] idx,
                        input logic l, input logic g);
        branchF      = b;
        hashed_pcF   = idx;
        local_predF  = l;
        global_predF = g;
    endtask

    task automatic setM(input logic b, input logic [5:0] idx, input logic o);
        branchM    = b;
        hashed_pcM = idx;
        pcsrcM     = o;
    endtask

    // queue this cycle's expectation, then advance to just after the next edge
    task automatic step(input string nm, input bit cpf, input logic pf,
                        input logic pw, input int bc, input int mc);
        exp_t e;
        e.nm  = nm;
        e.cpf = cpf;
        e.pf  = pf;
        e.pw  = pw;
        e.bc  = 32'(bc);
        e.mc  = 32'(mc);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        stallD = 0; stallE = 0; stallM = 0;
        flushD = 0; flushE = 0; flushM = 0;
        setF(0, 0, 0, 0);
        setM(0, 0, 0);
        @(posedge clk);
        #1;
        setF(1, 0, 1, 0);
        step("reset", 1, 1, 0, 0, 0);
        rst = 1'b0;

        setF(1, 3, 0, 1); setM(0, 0, 0);
        step("train_f0", 1, 0, 0, 0, 0);
        setM(1, 0, 1);
        step("invalid_m", 1, 0, 0, 0, 0);
        setM(0, 0, 0);
        step("train_f2", 1, 0, 0, 0, 0);
        setF(0, 0, 0, 0); setM(1, 3, 1);
        step("mis1", 1, 0, 1, 0, 0);
        step("mis2", 1, 0, 1, 1, 1);
        step("mis3_sat", 1, 0, 1, 2, 2);
        setF(1, 3, 0, 1); setM(0, 0, 0);
        step("use_global", 1, 1, 0, 3, 3);
        setF(1, 10, 0, 0);
        step("f7", 1, 0, 0, 3, 3);
        setF(0, 0, 0, 0);
        step("idle8", 1, 0, 0, 3, 3);
        setM(1, 3, 1);
        step("correct", 1, 0, 0, 3, 3);

        setM(1, 10, 1); stallM = 1;
        step("stall0", 1, 0, 1, 4, 3);
        step("stall1", 1, 0, 1, 4, 3);
        step("stall2", 1, 0, 1, 4, 3);
        stallM = 0;
        step("stall_rel", 1, 0, 1, 4, 3);

        setM(0, 0, 0); setF(1, 20, 1, 1);
        step("f14", 1, 1, 0, 5, 4);
        step("f15", 1, 1, 0, 5, 4);
        setF(0, 0, 0, 0); flushE = 1; stallE = 1;
        step("flush_stall", 1, 0, 0, 5, 4);
        flushE = 0; stallE = 0;
        setM(1, 20, 1);
        step("m17_ok", 1, 0, 0, 5, 4);
        setM(1, 20, 0);
        step("killed", 1, 0, 0, 6, 4);
        setM(0, 0, 0);
        step("after_kill", 1, 0, 0, 6, 4);

        setF(1, 5, 0, 1);
        step("f20", 1, 0, 0, 6, 4);
        setF(0, 0, 0, 0);
        step("idle21", 1, 0, 0, 6, 4);
        step("idle22", 1, 0, 0, 6, 4);
        setF(1, 5, 0, 1); setM(1, 5, 1);
        step("bypass_old", 1, 0, 1, 6, 4);
        setM(0, 0, 0);
        step("bypass_new", 1, 1, 0, 7, 5);

        setF(0, 0, 0, 0); rst = 1;
        step("rst_mid", 0, 0, 0, 7, 5);
        rst = 0; setF(1, 5, 0, 1); setM(1, 5, 1);
        step("rst_drop1", 1, 0, 0, 0, 0);
        setF(0, 0, 0, 0); setM(1, 5, 0);
        step("rst_drop2", 1, 0, 0, 0, 0);
        setM(0, 0, 0);
        step("end", 1, 0, 0, 0, 0);

        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            failures++;
            $display("FAIL drain queue left=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bp_chooser.md
# bp_chooser

Tournament chooser stage for the branch predictor. It consumes the per-branch local-history prediction and the global-history prediction in F and selects between them with a table of 2-bit choice counters (CPHT) to drive the final `pcsrcPF`. It carries every prediction down a F→D→E→M shadow pipeline. At M it compares the carried prediction against the resolved outcome and produces `predict_wrongM`, trains the chooser, and keeps branch and mispredict statistics.

## Interface
- `CPHT_DEPTH`, 6, log2 of the number of chooser counters.
- `clk` input 1 — clock.
- `rst` input 1 — synchronous, active-high reset.
- `hashed_pcF` input CPHT_DEPTH — chooser index for the instruction in F.
- `hashed_pcM` input CPHT_DEPTH — chooser index for the branch in M (supplied by the pipeline).
- `branchF` input 1 — predecoded: instruction in F is a conditional branch.
- `local_predF` input 1 — local-history prediction (1 = taken).
- `global_predF` input 1 — global-history prediction.
- `stallD`, `stallE`, `stallM` input 1 each — hold the corresponding stage register.
- `flushD`, `flushE`, `flushM` input 1 each — invalidate the corresponding stage register.
- `branchM` input 1 — instruction in M is a conditional branch.
- `pcsrcM` input 1 — resolved outcome in M (1 = taken).
- `pcsrcPF` output 1 — final prediction for F.
- `predict_wrongM` output 1 — M-stage branch was mispredicted.
- `branch_cnt` output 32 — retired predicted branches.
- `miss_cnt` output 32 — retired mispredicted branches.

## Operation
- CPHT: 2^CPHT_DEPTH entries of 2 bits. Values 00/01 select local; 10/11 select global.
- Prediction, combinational:
  - `choose_global = CPHT[hashed_pcF][1]`.
  - `pcsrcPF = branchF & (choose_global ? global_predF : local_predF)`.
- Shadow pipeline: registers D, E and M each hold {valid, local, global, final}, 4 bits.
  - Per stage X, in priority order:
    - rst or flushX: clear all bits.
    - Else if stallX: hold.
    - Else: load from the previous stage.
  - Stage D loads {branchF, local_predF, global_predF, pcsrcPF}.
  - Flush wins over stall.
- Mispredict, combinational: `predict_wrongM = branchM & validM & (finalM != pcsrcM)`.
- Retire event: `ret = branchM & validM & ~stallM`. Training and counting occur only on `ret`, so a stalled M never trains twice.
- Chooser training on `ret`, applied to `CPHT[hashed_pcM]`, saturating:
  - Local correct and global wrong: decrement.
  - Global correct and local wrong: increment.
  - Otherwise: hold.
- Statistics on `ret`:
  - `branch_cnt` increments by 1.
  - `miss_cnt` increments by 1 if `predict_wrongM`.
  - Both are 32-bit and wrap from FFFF_FFFF to 0.

## Timing
- `pcsrcPF` has zero latency from F inputs. A CPHT write at edge N is visible to an F read from cycle N+1.
- When the F read index equals the M write index in the same cycle, F sees the old value.
- Prediction latency F→M is 3 edges when there are no stalls. `predict_wrongM` is valid in the same cycle as `pcsrcM`.
- Reset, one cycle with `rst` high:
  - All CPHT entries become 01.
  - All stage registers clear, so `predict_wrongM` = 0.
  - `branch_cnt` = `miss_cnt` = 0.
  - `pcsrcPF` follows inputs, with the choice reset to local.
- `rst` asserted mid-stream discards in-flight predictions. No training occurs on the reset edge.
- A non-branch with `branchM`=1 but validM=0 (flushed path) produces no mispredict, training or count.
- Counter saturation: 00 does not decrement and 11 does not increment.

## Test plan
- **Reset:** drive rst 1 cycle with branchF=1, local=1, global=0 → `pcsrcPF`=1 (local chosen). `branch_cnt`=`miss_cnt`=0 and `predict_wrongM`=0.
- **Training:** same index, local=0, global=1, outcome taken, retired twice → CPHT 01→10→11. The next F prediction uses global (`pcsrcPF`=1). A third retire stays at 11.
- **Mispredict:** final=0 carried to M, `pcsrcM`=1, `branchM`=1 → `predict_wrongM`=1 in that cycle. `miss_cnt` and `branch_cnt` each +1.
- **Stall:** hold `stallM`=1 for 3 cycles with a valid mispredicting branch in M → `predict_wrongM`=1 throughout. Counters +1 only once, on the edge where `stallM`=0.
- **Flush vs stall:** `flushE`=1 and `stallE`=1 together → E becomes invalid. When that slot reaches M, `predict_wrongM`=0 and the counters are unchanged.
- **Same-index bypass:** in the same cycle, write index 5 (01→10) and read index 5 in F → F uses local. In the next cycle F uses global.
